// File: rtl/valve_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | valve_seq_pkg: shared types, status codes and line indices for   |
// | the pneumatic valve sequencer.                                   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package valve_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLOSE  = 3'd1,
      S_GUARD  = 3'd2,
      S_OPEN   = 3'd3,
      S_SETTLE = 3'd4,
      S_DWELL  = 3'd5,
      S_ABORT  = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   localparam logic [1:0] ST_OK     = 2'd0;
   localparam logic [1:0] ST_REJECT = 2'd1;
   localparam logic [1:0] ST_ABORT  = 2'd2;

   localparam int MUX_A  = 0;
   localparam int MUX_B  = 1;
   localparam int TRAP_A = 2;
   localparam int TRAP_B = 3;

   // Both mux inlets open at once would short the two inputs together.
   function automatic logic mux_conflict(input logic [MUX_B:0] mask);
      return mask[MUX_A] & mask[MUX_B];
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/valve_sequencer_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_timer: loadable saturating down-counter for guard, settle    |
// | and dwell intervals.                                             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module seq_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             expired
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/valve_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | valve_sequencer: break-before-make pneumatic valve controller    |
// | with guard/settle/dwell timing, mux interlock and abort.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module valve_sequencer
   import valve_seq_pkg::*;
#(
   parameter int N_CTRL        = 4,
   parameter int GUARD_CYCLES  = 100,
   parameter int SETTLE_CYCLES = 1000,
   parameter int DWELL_W       = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [N_CTRL-1:0]  cmd_open,
   input  logic [DWELL_W-1:0] cmd_dwell,
   input  logic               abort,
   output logic               done,
   output logic [1:0]         status,
   output logic               busy,
   output logic [N_CTRL-1:0]  cp_out
);

   localparam int TMR_W = max3($clog2(GUARD_CYCLES + 1), $clog2(SETTLE_CYCLES + 1), DWELL_W);
   localparam logic [TMR_W-1:0] GUARD_LOAD  = TMR_W'(GUARD_CYCLES - 1);
   localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

   state_t               state_q, state_d;
   logic [N_CTRL-1:0]    open_state_q, open_state_d;
   logic [N_CTRL-1:0]    close_set_q, close_set_d;
   logic [N_CTRL-1:0]    open_set_q, open_set_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [1:0]           status_q, status_d;
   logic                 tmr_load;
   logic [TMR_W-1:0]     tmr_val;
   logic                 tmr_expired;
   logic                 hold_start;

   seq_timer #(
      .WIDTH(TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   // Valve state changes land on the edge that enters CLOSE/OPEN, so cp_out
   // already shows the new state during that state's cycle.
   always_comb begin
      state_d      = state_q;
      open_state_d = open_state_q;
      close_set_d  = close_set_q;
      open_set_d   = open_set_q;
      dwell_d      = dwell_q;
      status_d     = status_q;
      tmr_load     = 1'b0;
      tmr_val      = '0;
      hold_start   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               close_set_d = open_state_q & ~cmd_open;
               open_set_d  = cmd_open & ~open_state_q;
               dwell_d     = cmd_dwell;
               if (mux_conflict(cmd_open[MUX_B:MUX_A])) begin
                  status_d = ST_REJECT;
                  state_d  = S_DONE;
               end else begin
                  open_state_d = open_state_q & cmd_open;
                  state_d      = S_CLOSE;
               end
            end
         end
         S_CLOSE: begin
            if ((close_set_q == '0) || (GUARD_CYCLES == 0)) begin
               open_state_d = open_state_q | open_set_q;
               state_d      = S_OPEN;
            end else begin
               tmr_load = 1'b1;
               tmr_val  = GUARD_LOAD;
               state_d  = S_GUARD;
            end
         end
         S_GUARD: begin
            if (tmr_expired) begin
               open_state_d = open_state_q | open_set_q;
               state_d      = S_OPEN;
            end
         end
         S_OPEN: begin
            if ((open_set_q != '0) && (SETTLE_CYCLES != 0)) begin
               tmr_load = 1'b1;
               tmr_val  = SETTLE_LOAD;
               state_d  = S_SETTLE;
            end else begin
               hold_start = 1'b1;
            end
         end
         S_SETTLE: begin
            hold_start = tmr_expired;
         end
         S_DWELL: begin
            if (tmr_expired) begin
               status_d = ST_OK;
               state_d  = S_DONE;
            end
         end
         S_ABORT: begin
            status_d = ST_ABORT;
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (hold_start) begin
         if (dwell_q != '0) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(dwell_q - DWELL_W'(1));
            state_d  = S_DWELL;
         end else begin
            status_d = ST_OK;
            state_d  = S_DONE;
         end
      end

      // Abort overrides everything, including a command arriving in IDLE.
      if (abort) begin
         open_state_d = '0;
         tmr_load     = 1'b0;
         state_d      = (state_q == S_IDLE) ? S_IDLE : S_ABORT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         open_state_q <= '0;
         close_set_q  <= '0;
         open_set_q   <= '0;
         dwell_q      <= '0;
         status_q     <= ST_OK;
      end else begin
         state_q      <= state_d;
         open_state_q <= open_state_d;
         close_set_q  <= close_set_d;
         open_set_q   <= open_set_d;
         dwell_q      <= dwell_d;
         status_q     <= status_d;
      end
   end

   assign cp_out    = ~open_state_q;
   assign cmd_ready = (state_q == S_IDLE) && !abort;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign status    = done ? status_q : ST_OK;

endmodule
`default_nettype wire

// File: tb/tb_valve_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_valve_sequencer: directed self-checking bench for             |
// | valve_sequencer (GUARD=3, SETTLE=5, DWELL_W=8).                  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_valve_sequencer;

   localparam int N_CTRL  = 4;
   localparam int DWELL_W = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [N_CTRL-1:0]  cmd_open;
   logic [DWELL_W-1:0] cmd_dwell;
   logic               abort;
   logic               done;
   logic [1:0]         status;
   logic               busy;
   logic [N_CTRL-1:0]  cp_out;

   int tests_run    = 0;
   int tests_failed = 0;

   valve_sequencer #(
      .N_CTRL        (N_CTRL),
      .GUARD_CYCLES  (3),
      .SETTLE_CYCLES (5),
      .DWELL_W       (DWELL_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_open  (cmd_open),
      .cmd_dwell (cmd_dwell),
      .abort     (abort),
      .done      (done),
      .status    (status),
      .busy      (busy),
      .cp_out    (cp_out)
   );

   always #5 clk = ~clk;

   // Drives one command for a single cycle; returns at the next negedge (T+1).
   task automatic send(input logic [N_CTRL-1:0] open_mask, input logic [DWELL_W-1:0] dwell);
      cmd_valid = 1'b1;
      cmd_open  = open_mask;
      cmd_dwell = dwell;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if (cp_out !== 4'b1111) begin tests_failed++; $display("FAIL reset_cp: got %b expected 1111", cp_out); end
      tests_run++;
      if ({cmd_ready, busy, done, status} !== 5'b10000) begin
         tests_failed++; $display("FAIL reset_ctl: ready/busy/done/status got %b expected 10000", {cmd_ready, busy, done, status});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_first_open();
      tests_run++;
      if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL first_ready: got %b expected 1", cmd_ready); end
      send(4'b0001, 8'd2);
      tests_run++;
      if (cp_out !== 4'b1111 || busy !== 1'b1) begin
         tests_failed++; $display("FAIL first_close: cp %b busy %b expected 1111 1", cp_out, busy);
      end
      @(negedge clk);
      tests_run++;
      if (cp_out !== 4'b1110) begin tests_failed++; $display("FAIL first_open_t2: got %b expected 1110", cp_out); end
      for (int k = 3; k <= 10; k++) begin
         @(negedge clk);
         tests_run++;
         if (done !== (k == 10)) begin tests_failed++; $display("FAIL first_done_t%0d: got %b expected %b", k, done, (k == 10)); end
      end
      tests_run++;
      if (status !== 2'd0) begin tests_failed++; $display("FAIL first_status: got %0d expected 0", status); end
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         tests_failed++; $display("FAIL first_idle: ready %b busy %b expected 1 0", cmd_ready, busy);
      end
   endtask

   task automatic test_break_before_make();
      send(4'b0110, 8'd1);
      for (int k = 1; k <= 4; k++) begin
         tests_run++;
         if (cp_out !== 4'b1111) begin tests_failed++; $display("FAIL bbm_guard_t%0d: got %b expected 1111", k, cp_out); end
         @(negedge clk);
      end
      tests_run++;
      if (cp_out !== 4'b1001) begin tests_failed++; $display("FAIL bbm_open_t5: got %b expected 1001", cp_out); end
      for (int k = 6; k <= 12; k++) begin
         @(negedge clk);
         tests_run++;
         if (done !== (k == 12) || cp_out !== 4'b1001) begin
            tests_failed++; $display("FAIL bbm_hold_t%0d: done %b cp %b expected %b 1001", k, done, cp_out, (k == 12));
         end
      end
      @(negedge clk);
   endtask

   task automatic test_interlock();
      tests_run++;
      if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL ilk_ready: got %b expected 1", cmd_ready); end
      send(4'b0011, 8'd5);
      tests_run++;
      if (done !== 1'b1 || status !== 2'd1 || cp_out !== 4'b1001) begin
         tests_failed++; $display("FAIL ilk_reject: done %b status %0d cp %b expected 1 1 1001", done, status, cp_out);
      end
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || cmd_ready !== 1'b1 || cp_out !== 4'b1001) begin
         tests_failed++; $display("FAIL ilk_after: done %b ready %b cp %b expected 0 1 1001", done, cmd_ready, cp_out);
      end
   endtask

   task automatic test_identical();
      send(4'b0110, 8'd0);
      for (int k = 1; k <= 3; k++) begin
         tests_run++;
         if (cp_out !== 4'b1001 || done !== (k == 3)) begin
            tests_failed++; $display("FAIL ident_t%0d: cp %b done %b expected 1001 %b", k, cp_out, done, (k == 3));
         end
         if (k < 3) @(negedge clk);
      end
      tests_run++;
      if (status !== 2'd0) begin tests_failed++; $display("FAIL ident_status: got %0d expected 0", status); end
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL ident_ready: got %b expected 1", cmd_ready); end
   endtask

   task automatic test_reset_mid();
      send(4'b0001, 8'd0);
      tests_run++;
      if (cp_out !== 4'b1111 || busy !== 1'b1) begin
         tests_failed++; $display("FAIL rmid_close: cp %b busy %b expected 1111 1", cp_out, busy);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (cp_out !== 4'b1111 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
         tests_failed++; $display("FAIL rmid_reset: cp %b busy %b ready %b done %b expected 1111 0 1 0", cp_out, busy, cmd_ready, done);
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests_run++;
         if (done !== 1'b0 || cp_out !== 4'b1111) begin
            tests_failed++; $display("FAIL rmid_quiet_%0d: done %b cp %b expected 0 1111", k, done, cp_out);
         end
      end
   endtask

   task automatic test_abort();
      send(4'b0100, 8'd3);
      @(negedge clk);
      tests_run++;
      if (cp_out !== 4'b1011) begin tests_failed++; $display("FAIL abort_open: got %b expected 1011", cp_out); end
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      tests_run++;
      if (cp_out !== 4'b1111 || busy !== 1'b1 || done !== 1'b0) begin
         tests_failed++; $display("FAIL abort_close: cp %b busy %b done %b expected 1111 1 0", cp_out, busy, done);
      end
      @(negedge clk);
      tests_run++;
      if (done !== 1'b1 || status !== 2'd2) begin
         tests_failed++; $display("FAIL abort_done: done %b status %0d expected 1 2", done, status);
      end
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++; $display("FAIL abort_idle: ready %b busy %b done %b expected 1 0 0", cmd_ready, busy, done);
      end
   endtask

   task automatic test_idle_abort();
      send(4'b1000, 8'd0);
      for (int k = 2; k <= 8; k++) begin
         @(negedge clk);
         tests_run++;
         if (done !== (k == 8)) begin tests_failed++; $display("FAIL iabort_done_t%0d: got %b expected %b", k, done, (k == 8)); end
      end
      @(negedge clk);
      tests_run++;
      if (cp_out !== 4'b0111) begin tests_failed++; $display("FAIL iabort_state: got %b expected 0111", cp_out); end
      abort     = 1'b1;
      cmd_valid = 1'b1;
      cmd_open  = 4'b0100;
      cmd_dwell = 8'd0;
      #1;
      tests_run++;
      if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL iabort_ready: got %b expected 0", cmd_ready); end
      @(negedge clk);
      abort     = 1'b0;
      cmd_valid = 1'b0;
      tests_run++;
      if (cp_out !== 4'b1111 || busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++; $display("FAIL iabort_close: cp %b busy %b done %b expected 1111 0 0", cp_out, busy, done);
      end
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || cp_out !== 4'b1111) begin
         tests_failed++; $display("FAIL iabort_noaccept: busy %b cp %b expected 0 1111", busy, cp_out);
      end
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_open  = '0;
      cmd_dwell = '0;
      abort     = 1'b0;
      @(negedge clk);
      test_reset();
      test_first_open();
      test_break_before_make();
      test_interlock();
      test_identical();
      test_reset_mid();
      test_abort();
      test_idle_abort();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
